// File: rtl/global_param.sv
// Shared constants for the interrupt controller slice: SFR addresses,
// source indices, arbiter state encoding and priority levels.
package global_param;

  localparam logic [7:0] SFR_IE = 8'hA8;
  localparam logic [7:0] SFR_IP = 8'hB8;

  localparam int         N_SRC   = 5;
  localparam logic [2:0] SRC_IE0 = 3'd0;
  localparam logic [2:0] SRC_TF0 = 3'd1;
  localparam logic [2:0] SRC_IE1 = 3'd2;
  localparam logic [2:0] SRC_TF1 = 3'd3;
  localparam logic [2:0] SRC_SER = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } arb_state_e;

  typedef enum logic {
    LVL_LOW  = 1'b0,
    LVL_HIGH = 1'b1
  } prio_lvl_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority selector: highest IP level wins, then the lowest source index.
module irq_prio_enc
  import global_param::*;
(
  input  logic [N_SRC-1:0] elig,
  input  logic [N_SRC-1:0] ip,
  output logic             valid,
  output logic [2:0]       idx,
  output prio_lvl_e        lvl
);

  logic [N_SRC-1:0] hi_elig;
  logic [N_SRC-1:0] cand;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    hi_elig = elig & ip;
    valid   = |elig;
    lvl     = (|hi_elig) ? LVL_HIGH : LVL_LOW;
    cand    = (|hi_elig) ? hi_elig : elig;
    idx     = '0;
    // Scanning downward lets the lowest set index be the final assignment.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_priority_arb.sv
// 8051-style two-level interrupt arbiter: IE/IP SFRs, in-service tracking,
// request/ack handshake with the CPU and hardware flag-clear pulses.
module irq_priority_arb
  import global_param::*;
#(
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_flag,
  input  logic [1:0]       it_cfg,
  input  logic [7:0]       sfr_addr,
  input  logic [7:0]       sfr_wdata,
  input  logic             sfr_we,
  output logic [7:0]       sfr_rdata,
  output logic             sfr_hit,
  input  logic             int_window,
  output logic             irq_req,
  output logic [15:0]      irq_vector,
  input  logic             irq_ack,
  input  logic             reti,
  output logic [N_SRC-1:0] flag_clr
);

  logic             ie_ea;
  logic [N_SRC-1:0] ie_en;
  logic [N_SRC-1:0] ip_q;
  logic             ins_low;
  logic             ins_high;
  arb_state_e       state;
  logic [2:0]       sel_idx;
  prio_lvl_e        sel_lvl;

  logic [N_SRC-1:0] base_elig;
  logic [N_SRC-1:0] elig;
  logic             enc_valid;
  logic [2:0]       enc_idx;
  prio_lvl_e        enc_lvl;
  logic [N_SRC-1:0] clr_ok;
  logic             take_ack;

  // Bits 6:5 of the write data have no backing register in either SFR.
  logic unused_wdata;
  assign unused_wdata = ^sfr_wdata[6:5];

  always_comb begin
    sfr_hit   = 1'b0;
    sfr_rdata = '0;
    if (sfr_addr == SFR_IE) begin
      sfr_hit   = 1'b1;
      sfr_rdata = {ie_ea, 2'b00, ie_en};
    end else if (sfr_addr == SFR_IP) begin
      sfr_hit   = 1'b1;
      sfr_rdata = {3'b000, ip_q};
    end
  end

  // A source must sit strictly above the level currently in service.
  assign base_elig = src_flag & ie_en & {N_SRC{ie_ea}};
  assign elig      = ins_high ? '0 : (ins_low ? (base_elig & ip_q) : base_elig);

  irq_prio_enc u_enc (
    .elig  (elig),
    .ip    (ip_q),
    .valid (enc_valid),
    .idx   (enc_idx),
    .lvl   (enc_lvl)
  );

  // Edge-triggered externals are cleared by hardware; level ones and serial are not.
  assign clr_ok   = {1'b0, 1'b1, it_cfg[1], 1'b1, it_cfg[0]};
  assign take_ack = (state == ST_REQ) && irq_ack;

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_ea      <= 1'b0;
      ie_en      <= '0;
      ip_q       <= '0;
      ins_low    <= 1'b0;
      ins_high   <= 1'b0;
      state      <= ST_IDLE;
      sel_idx    <= '0;
      sel_lvl    <= LVL_LOW;
      irq_req    <= 1'b0;
      irq_vector <= VEC_BASE;
      flag_clr   <= '0;
    end else begin
      flag_clr <= '0;

      if (sfr_we && sfr_addr == SFR_IE) begin
        ie_ea <= sfr_wdata[7];
        ie_en <= sfr_wdata[N_SRC-1:0];
      end
      if (sfr_we && sfr_addr == SFR_IP) ip_q <= sfr_wdata[N_SRC-1:0];

      // An ack in the same cycle as reti swallows the reti.
      if (take_ack) begin
        if (sel_lvl == LVL_HIGH) ins_high <= 1'b1;
        else                     ins_low  <= 1'b1;
      end else if (reti) begin
        if (ins_high)     ins_high <= 1'b0;
        else if (ins_low) ins_low  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (int_window && enc_valid) begin
            state      <= ST_REQ;
            sel_idx    <= enc_idx;
            sel_lvl    <= enc_lvl;
            irq_req    <= 1'b1;
            irq_vector <= VEC_BASE + 16'(enc_idx) * VEC_STRIDE;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state    <= ST_IDLE;
            irq_req  <= 1'b0;
            flag_clr <= clr_ok & (N_SRC'(1) << sel_idx);
          end else if (!base_elig[sel_idx]) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_priority_arb.md
IRQ_PRIORITY_ARB -- requirements
Module: irq_priority_arb

Interface
REQ-001 Parameter VEC_BASE, default 16'h0003, vector address of source 0.
REQ-002 Parameter VEC_STRIDE, default 16'h0008, vector spacing per source index.
REQ-003 Port clk in 1: single clock; every register updates on its rising edge.
REQ-004 Port reset in 1: synchronous reset, active-high, sampled on the rising edge of clk.
REQ-005 Port src_flag in 5: pending flags from the peripherals; bit0 IE0, bit1 TF0, bit2 IE1, bit3 TF1, bit4 RI|TI.
REQ-006 Port it_cfg in 2: TCON IT0/IT1 (1 = edge mode for IE0/IE1).
REQ-007 Port sfr_addr in 8, sfr_wdata in 8, sfr_we in 1: SFR write bus.
REQ-008 Port sfr_rdata out 8, sfr_hit out 1: combinational read data, and a hit flag for IE (8'hA8) or IP (8'hB8).
REQ-009 Port int_window in 1: the CPU is at an instruction boundary where it can take an interrupt.
REQ-010 Port irq_req out 1, irq_vector out 16: interrupt request to the CPU and its vector.
REQ-011 Port irq_ack in 1: one-cycle pulse; the CPU has accepted the request and begins the LCALL.
REQ-012 Port reti in 1: one-cycle pulse; a RETI has executed.
REQ-013 Port flag_clr out 5: one-cycle hardware-clear pulses back to the peripherals.

Function
REQ-014 IE register: bit7 EA, bits4:0 enables. All other bits SHALL read 0 and ignore writes.
REQ-015 IP register: bits4:0 are the priorities (1 = high). Bits7:5 SHALL read 0.
REQ-016 An SFR write SHALL take effect on the clock edge at which sfr_we is sampled. A same-address read SHALL return the new value from the next cycle.
REQ-017 A source is eligible when src_flag[i] & en[i] & EA, and its level (IP[i]) is above the current in-service level.
REQ-018 In-service levels: NONE < LOW < HIGH. They are tracked by two bits, ins_low and ins_high.
REQ-019 Among eligible sources, the block SHALL select the highest IP level first, then the lowest index.
REQ-020 State IDLE -> REQ when int_window=1 and at least one source is eligible. In the same edge it SHALL latch sel_idx and sel_lvl.
REQ-021 In REQ: irq_req=1, and irq_vector = VEC_BASE + sel_idx*VEC_STRIDE, held stable until exit.
REQ-022 REQ -> IDLE on irq_ack. In the same edge it SHALL set ins_high or ins_low per sel_lvl and pulse flag_clr[sel_idx] for one cycle.
REQ-023 flag_clr SHALL pulse for TF0 and TF1 always, for IE0/IE1 only when the matching it_cfg bit=1, and never for source 4.
REQ-024 REQ -> IDLE without acknowledgement, with irq_req deasserted next cycle, when the latched source is no longer eligible: flag dropped, enable cleared, or EA cleared.
REQ-025 A higher-priority source arriving during REQ SHALL NOT change the latched vector. It SHALL be arbitrated on the next IDLE pass.
REQ-026 Request latency SHALL be 1 clock: eligible source with int_window=1 at edge N gives irq_req=1 after edge N.
REQ-027 On reti: if ins_high is set, clear ins_high; otherwise clear ins_low. reti with nothing in service SHALL be ignored.
REQ-028 When reti and an eligible request occur in the same cycle, the request SHALL be evaluated against the in-service level from before the clear.
REQ-029 When irq_ack and reti occur in the same cycle, the ack SHALL win and reti SHALL be discarded.
REQ-030 When an SFR write and REQ entry occur in the same cycle, eligibility SHALL use the old IE/IP values.
REQ-031 A high-level source SHALL preempt LOW in service. Nothing SHALL preempt HIGH in service. Maximum nesting depth is 2.

Reset
REQ-032 Reset SHALL set IE=0, IP=0, ins_low=0, ins_high=0, state=IDLE, irq_req=0, irq_vector=VEC_BASE, and flag_clr=0.
REQ-033 Reset asserted mid-REQ SHALL drop irq_req on the next edge and SHALL NOT generate any flag_clr pulse.

Structure
REQ-034 The shared global_param package SHALL hold the SFR addresses (IE 8'hA8, IP 8'hB8), the source index constants, and the state encoding IDLE/REQ.
REQ-035 The fixed-priority selector (eligibility vector in, index and level out) SHALL be a combinational sub-module named irq_prio_enc.

Verification
REQ-036 IE=8'h81, src_flag=5'b00001, int_window=1 -> irq_req after 1 clk, vector 16'h0003. On ack: flag_clr=5'b00001 only if it_cfg[0]=1.
REQ-037 IE=8'h9F, IP=0, src_flag=5'b11010 -> vector 16'h000B (TF0). After ack + reti, the next request is 16'h001B (TF1).
REQ-038 Start with LOW TF0 in service, then IP=8'h10 and serial flag set -> preempt with vector 16'h0023, flag_clr=0. Two retis clear HIGH, then LOW.
REQ-039 In REQ for TF1, write IE=8'h00 -> irq_req drops next cycle, no flag_clr, state IDLE.
REQ-040 Same-cycle irq_ack and reti -> ins level set, reti ignored. Separately, reset pulsed during REQ -> all outputs at reset values, IE reads 8'h00.
